// File: rtl/comm_demap_pack_if.sv
// Bin stream in, packed-word FIFO out, plus per-bin decision and status taps.
interface comm_demap_pack_if #(
    parameter int unsigned WIDTH = 11
);
    logic [1:0]       mode;
    logic             valid_i;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] ai;
    logic             valid_o;
    logic [31:0]      data_o;
    logic             ack_o;
    logic             valid_raw;
    logic [3:0]       raw;
    logic             sym_o;
    logic             ovf;
    logic             mode_err;

    modport master (
        output mode, valid_i, ar, ai, ack_o,
        input  valid_o, data_o, valid_raw, raw, sym_o, ovf, mode_err
    );

    modport slave (
        input  mode, valid_i, ar, ai, ack_o,
        output valid_o, data_o, valid_raw, raw, sym_o, ovf, mode_err
    );
endinterface

// File: rtl/comm_demap_pack.sv
// OFDM receive demapper: hard-decides BPSK/QPSK/16-QAM data bins and packs the
// bits LSB-first into 32-bit words delivered through a valid/ack FIFO.
module comm_demap_pack #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned NFFT      = 64,
    parameter int unsigned FIRST_BIN = 4,
    parameter int unsigned NBINS     = 32,
    parameter int unsigned THRESH    = 256,
    parameter int unsigned DEPTH     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    comm_demap_pack_if.slave  bus
);
    localparam int unsigned BW = $clog2(NFFT);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [BW-1:0]  BIN_LAST = BW'(NFFT - 1);
    localparam logic [BW-1:0]  BIN_LO   = BW'(FIRST_BIN);
    localparam logic [BW-1:0]  BIN_HI   = BW'(FIRST_BIN + NBINS - 1);
    localparam logic [WIDTH:0] TH       = (WIDTH + 1)'(THRESH);
    localparam logic [AW:0]    FULL     = (AW + 1)'(DEPTH);

    logic [BW-1:0] bin;
    logic [1:0]    mode_q;
    logic [31:0]   pack;
    logic [4:0]    ptr;
    logic          done_q;
    logic [31:0]   word_q;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          first_c;
    logic [1:0]    mode_c;
    logic          data_c;
    logic          si_c;
    logic          sq_c;
    logic [WIDTH:0] ext_r_c;
    logic [WIDTH:0] ext_i_c;
    logic [WIDTH:0] mag_r_c;
    logic [WIDTH:0] mag_i_c;
    logic [3:0]    raw_c;
    logic [3:0]    mask_c;
    logic [2:0]    bps_c;
    logic [31:0]   base_pack_c;
    logic [4:0]    base_ptr_c;
    logic [31:0]   wmask_c;
    logic [31:0]   pack_nxt_c;
    logic [5:0]    sum_c;
    logic          wrap_c;

    logic          pop_c;
    logic          push_c;
    logic          drop_c;
    logic [AW:0]   count_nxt_c;
    logic [AW-1:0] rd_nxt_c;
    logic [31:0]   head_c;

    // Mode in force for this beat: bin 0 samples the input, later bins use the latch.
    assign first_c = (bin == '0);
    assign mode_c  = first_c ? bus.mode : mode_q;
    assign data_c  = bus.valid_i && (bin >= BIN_LO) && (bin <= BIN_HI) && (mode_c != 2'd3);

    assign si_c    = bus.ar[WIDTH-1];
    assign sq_c    = bus.ai[WIDTH-1];
    assign ext_r_c = {bus.ar[WIDTH-1], bus.ar};
    assign ext_i_c = {bus.ai[WIDTH-1], bus.ai};
    assign mag_r_c = si_c ? -ext_r_c : ext_r_c;
    assign mag_i_c = sq_c ? -ext_i_c : ext_i_c;

    always_comb begin
        raw_c  = {3'b000, si_c};
        mask_c = 4'b0001;
        bps_c  = 3'd1;
        case (mode_c)
            2'd1: begin
                raw_c  = {2'b00, sq_c, si_c};
                mask_c = 4'b0011;
                bps_c  = 3'd2;
            end
            2'd2: begin
                raw_c  = {(mag_i_c < TH), sq_c, (mag_r_c < TH), si_c};
                mask_c = 4'b1111;
                bps_c  = 3'd4;
            end
            default: ;
        endcase
    end

    // Pointer stays bps-aligned, so a bin's bits never straddle a word boundary.
    assign base_pack_c = first_c ? '0 : pack;
    assign base_ptr_c  = first_c ? '0 : ptr;
    assign wmask_c     = 32'(mask_c) << base_ptr_c;
    assign pack_nxt_c  = (base_pack_c & ~wmask_c) | ((32'(raw_c) << base_ptr_c) & wmask_c);
    assign sum_c       = {1'b0, base_ptr_c} + 6'(bps_c);
    assign wrap_c      = sum_c[5];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bin           <= '0;
            mode_q        <= '0;
            pack          <= '0;
            ptr           <= '0;
            done_q        <= 1'b0;
            word_q        <= '0;
            bus.valid_raw <= 1'b0;
            bus.raw       <= '0;
            bus.sym_o     <= 1'b0;
            bus.mode_err  <= 1'b0;
        end else begin
            done_q        <= data_c && wrap_c;
            bus.valid_raw <= data_c;
            bus.raw       <= data_c ? raw_c : '0;
            bus.sym_o     <= bus.valid_i && (bin == BIN_LAST);
            if (data_c && wrap_c) begin
                word_q <= pack_nxt_c;
            end
            if (bus.valid_i) begin
                bin <= bin + BW'(1);
                if (first_c) begin
                    mode_q <= bus.mode;
                    if (bus.mode == 2'd3) begin
                        bus.mode_err <= 1'b1;
                    end
                end
                if (data_c) begin
                    pack <= pack_nxt_c;
                    ptr  <= sum_c[4:0];
                end else if (first_c) begin
                    pack <= '0;
                    ptr  <= '0;
                end
            end
        end
    end

    // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
    assign pop_c       = bus.valid_o && bus.ack_o;
    assign push_c      = done_q && ((count != FULL) || pop_c);
    assign drop_c      = done_q && !push_c;
    assign count_nxt_c = count + (AW + 1)'(push_c) - (AW + 1)'(pop_c);
    assign rd_nxt_c    = rd_ptr + AW'(pop_c);
    assign head_c      = (push_c && (wr_ptr == rd_nxt_c)) ? word_q : mem[rd_nxt_c];

    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr] <= word_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr      <= rd_nxt_c;
            count       <= count_nxt_c;
            bus.valid_o <= (count_nxt_c != '0);
            if (count_nxt_c != '0) begin
                bus.data_o <= head_c;
            end
            if (drop_c) begin
                bus.ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_comm_demap_pack.sv
// Directed bench for comm_demap_pack: per-symbol vector table plus hand-written
// latency, mode-latch, back-pressure, overflow, mode-3 and reset sequences.
module tb_comm_demap_pack;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    comm_demap_pack_if #(.WIDTH(11)) bus ();

    comm_demap_pack #(
        .WIDTH(11), .NFFT(64), .FIRST_BIN(4), .NBINS(32), .THRESH(256), .DEPTH(8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  mode;
        logic [10:0] ar;
        logic [10:0] ai;
        logic [3:0]  raw;
        logic [31:0] word;
        int          nwords;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    int          sym_cnt;
    logic [3:0]  raw_log [$];
    logic [31:0] got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Records a pop that the coming edge performs, then advances one cycle.
    task automatic tick();
        if (bus.valid_o && bus.ack_o) got.push_back(bus.data_o);
        @(posedge CLK);
        #1;
        if (bus.valid_raw) raw_log.push_back(bus.raw);
        if (bus.sym_o) sym_cnt++;
    endtask

    task automatic clear_logs();
        raw_log.delete();
        got.delete();
        sym_cnt = 0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        clear_logs();
    endtask

    task automatic send_sym(input logic [1:0] m, input logic [10:0] r, input logic [10:0] i);
        for (int b = 0; b < 64; b++) begin
            bus.valid_i = 1'b1;
            bus.mode    = m;
            bus.ar      = r;
            bus.ai      = i;
            tick();
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic check_raws(input string tag, input logic [3:0] exp_raw, input int exp_n);
        int bad = 0;
        foreach (raw_log[k]) if (raw_log[k] !== exp_raw) bad++;
        chk($sformatf("%s raw_count", tag), 32'(raw_log.size()), 32'(exp_n));
        chk($sformatf("%s raw_value_errs", tag), 32'(bad), 32'd0);
    endtask

    task automatic check_words(input string tag, input logic [31:0] exp_word, input int exp_n);
        int bad = 0;
        foreach (got[k]) if (got[k] !== exp_word) bad++;
        chk($sformatf("%s word_count", tag), 32'(got.size()), 32'(exp_n));
        chk($sformatf("%s word_value_errs", tag), 32'(bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{mode: 2'd0, ar: -11'sd5,    ai: 11'sd7,    raw: 4'h1, word: 32'hFFFFFFFF, nwords: 1};
        vecs[1] = '{mode: 2'd0, ar: 11'sd5,     ai: -11'sd7,   raw: 4'h0, word: 32'h00000000, nwords: 1};
        vecs[2] = '{mode: 2'd1, ar: 11'sd300,   ai: -11'sd300, raw: 4'h2, word: 32'hAAAAAAAA, nwords: 2};
        vecs[3] = '{mode: 2'd1, ar: -11'sd300,  ai: -11'sd300, raw: 4'h3, word: 32'hFFFFFFFF, nwords: 2};
        vecs[4] = '{mode: 2'd2, ar: -11'sd100,  ai: 11'sd400,  raw: 4'h3, word: 32'h33333333, nwords: 4};
        vecs[5] = '{mode: 2'd2, ar: 11'sd255,   ai: -11'sd256, raw: 4'h6, word: 32'h66666666, nwords: 4};
        vecs[6] = '{mode: 2'd2, ar: -11'sd1024, ai: 11'sd1023, raw: 4'h1, word: 32'h11111111, nwords: 4};
        vecs[7] = '{mode: 2'd2, ar: 11'sd0,     ai: -11'sd1,   raw: 4'hE, word: 32'hEEEEEEEE, nwords: 4};

        bus.mode = 2'd0; bus.valid_i = 1'b0; bus.ar = '0; bus.ai = '0; bus.ack_o = 1'b0;
        sym_cnt = 0;
        idle(2);
        chk("reset_outputs",
            32'({bus.valid_o, bus.valid_raw, bus.raw, bus.sym_o, bus.ovf, bus.mode_err}), 32'd0);
        chk("reset_data_o", bus.data_o, 32'd0);
        RST = 1'b0;
        clear_logs();

        // Per-symbol decision/packing table, consumer always ready.
        bus.ack_o = 1'b1;
        for (int v = 0; v < 8; v++) begin
            clear_logs();
            send_sym(vecs[v].mode, vecs[v].ar, vecs[v].ai);
            idle(4);
            check_raws($sformatf("vec%0d", v), vecs[v].raw, 32);
            check_words($sformatf("vec%0d", v), vecs[v].word, vecs[v].nwords);
            chk($sformatf("vec%0d sym_pulses", v), 32'(sym_cnt), 32'd1);
        end

        // QPSK baseline with alternating bins and word latency check.
        clear_logs();
        for (int b = 0; b < 64; b++) begin
            bus.valid_i = 1'b1;
            bus.mode    = 2'd1;
            bus.ar      = ((b - 4) % 2 == 0) ? 11'sd300 : -11'sd300;
            bus.ai      = ((b - 4) % 2 == 0) ? -11'sd300 : 11'sd300;
            tick();
            if (b == 4) chk("qpsk first_raw", 32'({bus.valid_raw, bus.raw}), 32'h12);
            if (b == 5) chk("qpsk second_raw", 32'({bus.valid_raw, bus.raw}), 32'h11);
            if (b == 19) chk("qpsk valid_o_before_push", 32'(bus.valid_o), 32'd0);
            if (b == 20) chk("qpsk valid_o_latency", {bus.valid_o ? 32'd1 : 32'd0} ^ bus.data_o, 32'h66666667);
        end
        idle(4);
        begin
            int bad = 0;
            foreach (raw_log[k]) if (raw_log[k] !== ((k % 2 == 0) ? 4'h2 : 4'h1)) bad++;
            chk("qpsk alt_raw_errs", 32'(bad), 32'd0);
            chk("qpsk raw_count", 32'(raw_log.size()), 32'd32);
        end
        check_words("qpsk", 32'h66666666, 2);
        chk("qpsk sym_pulses", 32'(sym_cnt), 32'd1);

        // Mode switched mid-symbol must be ignored until the next bin 0.
        clear_logs();
        for (int b = 0; b < 64; b++) begin
            bus.valid_i = 1'b1;
            bus.mode    = (b < 10) ? 2'd0 : 2'd2;
            bus.ar      = -11'sd5;
            bus.ai      = 11'sd7;
            tick();
        end
        idle(4);
        check_raws("latch_bpsk", 4'h1, 32);
        check_words("latch_bpsk", 32'hFFFFFFFF, 1);
        clear_logs();
        send_sym(2'd2, -11'sd100, 11'sd400);
        idle(6);
        check_raws("latch_qam", 4'h3, 32);
        check_words("latch_qam", 32'h33333333, 4);

        // Full FIFO with a pop in the same cycle as the push: nothing lost.
        do_reset();
        bus.ack_o = 1'b0;
        send_sym(2'd2, -11'sd100, 11'sd400);
        send_sym(2'd2, 11'sd255, -11'sd256);
        idle(2);
        chk("fullpop held_head", bus.data_o, 32'h33333333);
        for (int b = 0; b < 64; b++) begin
            bus.valid_i = 1'b1;
            bus.mode    = 2'd2;
            bus.ar      = 11'sd0;
            bus.ai      = -11'sd1;
            tick();
            if (b == 11) bus.ack_o = 1'b1;
            if (b == 12) chk("fullpop ovf_after_collision", 32'({bus.ovf, bus.valid_o}), 32'h1);
        end
        idle(12);
        chk("fullpop word_count", 32'(got.size()), 32'd12);
        begin
            int bad = 0;
            foreach (got[k]) if (got[k] !== ((k < 4) ? 32'h33333333 : (k < 8) ? 32'h66666666 : 32'hEEEEEEEE)) bad++;
            chk("fullpop order_errs", 32'(bad), 32'd0);
        end
        chk("fullpop ovf_final", 32'(bus.ovf), 32'd0);

        // Overflow: three symbols into an 8-deep FIFO with no consumer.
        do_reset();
        bus.ack_o = 1'b0;
        send_sym(2'd2, -11'sd100, 11'sd400);
        send_sym(2'd2, 11'sd255, -11'sd256);
        chk("ovf not_yet", 32'(bus.ovf), 32'd0);
        send_sym(2'd2, 11'sd0, -11'sd1);
        idle(3);
        chk("ovf sticky_set", 32'(bus.ovf), 32'd1);
        chk("ovf head_stable", bus.data_o, 32'h33333333);
        bus.ack_o = 1'b1;
        idle(14);
        chk("ovf drained_count", 32'(got.size()), 32'd8);
        begin
            int bad = 0;
            foreach (got[k]) if (got[k] !== ((k < 4) ? 32'h33333333 : 32'h66666666)) bad++;
            chk("ovf order_errs", 32'(bad), 32'd0);
        end
        chk("ovf empty_after_drain", 32'(bus.valid_o), 32'd0);

        // Reserved mode: consumed silently, flagged.
        do_reset();
        bus.ack_o = 1'b1;
        send_sym(2'd3, -11'sd300, -11'sd300);
        idle(4);
        chk("mode3 raw_count", 32'(raw_log.size()), 32'd0);
        chk("mode3 word_count", 32'(got.size()), 32'd0);
        chk("mode3 flags", 32'({bus.mode_err, bus.ovf}), 32'h2);
        chk("mode3 sym_pulses", 32'(sym_cnt), 32'd1);

        // Reset asserted mid-symbol at bin 20, with a word already queued.
        bus.ack_o = 1'b0;
        for (int b = 0; b < 21; b++) begin
            bus.valid_i = 1'b1;
            bus.mode    = 2'd1;
            bus.ar      = -11'sd300;
            bus.ai      = -11'sd300;
            tick();
        end
        bus.valid_i = 1'b0;
        chk("prerst busy", 32'({bus.valid_o, bus.valid_raw, bus.mode_err}), 32'h7);
        RST = 1'b1;
        #1;
        chk("rst async_outputs",
            32'({bus.valid_o, bus.valid_raw, bus.raw, bus.sym_o, bus.ovf, bus.mode_err}), 32'd0);
        chk("rst async_data_o", bus.data_o, 32'd0);
        idle(1);
        RST = 1'b0;
        clear_logs();
        bus.ack_o = 1'b1;
        for (int b = 0; b < 64; b++) begin
            bus.valid_i = 1'b1;
            bus.mode    = 2'd0;
            bus.ar      = -11'sd5;
            bus.ai      = 11'sd7;
            tick();
            if (b == 62) chk("postrst no_early_sym", 32'(sym_cnt), 32'd0);
        end
        idle(4);
        chk("postrst sym_pulses", 32'(sym_cnt), 32'd1);
        check_raws("postrst", 4'h1, 32);
        check_words("postrst", 32'hFFFFFFFF, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
